// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register map, STATUS/CTRL bit
// positions and the frame FSM states. UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    localparam int CTRL_INT_EN = 0;
    localparam int CTRL_TX_EN  = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign rdata  = mem[rdPtr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped UART transmitter with TX FIFO, programmable divisor and level
// interrupt. Define UART_TX_PARITY_EN for an even-parity bit (11-bit frame).
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] D,
    input  logic [1:0]  A,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] Dout,
    output logic        tx,
    output logic        INT,
    output logic [2:0]  dbgState
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    txState_t        state, stateNext;
    logic [CW-1:0]   fifoCount;
    logic [7:0]      fifoData;
    logic            fifoFull, fifoEmpty, fifoPop, dataWr, regWr;
    logic [15:0]     div, bitDiv, bitCnt;
    logic [2:0]      bitIdx;
    logic [7:0]      shifter;
    logic            txEn, intEn, ovf, busy, bitEnd;
    logic [4:0]      cntWide;
    logic [3:0]      cntField;

    assign regWr    = we & be[0];
    assign dataWr   = regWr & (A == ADDR_DATA);
    assign busy     = (state != S_IDLE);
    assign dbgState = state;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dataWr),
        .wdata (D[7:0]),
        .pop   (fifoPop),
        .rdata (fifoData),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div   <= 16'(DIVISOR);
            txEn  <= 1'b1;
            intEn <= 1'b0;
            ovf   <= 1'b0;
            INT   <= 1'b0;
        end else begin
            INT <= intEn & fifoEmpty & ~busy;
            if (dataWr && fifoFull && !fifoPop)
                ovf <= 1'b1;
            else if (regWr && A == ADDR_STATUS)
                ovf <= 1'b0;
            if (regWr && A == ADDR_CTRL) begin
                txEn  <= D[CTRL_TX_EN];
                intEn <= D[CTRL_INT_EN];
            end
            if (regWr && A == ADDR_DIV)
                div <= (D[15:0] < 16'd2) ? 16'd2 : D[15:0];
        end
    end

    // Count field is 4 bits wide; a 16-deep FIFO holding 16 reads as 15.
    always_comb begin
        cntWide  = 5'(fifoCount);
        cntField = cntWide[4] ? 4'hF : cntWide[3:0];
        Dout     = '0;
        case (A)
            ADDR_STATUS: begin
                Dout[ST_BUSY]             = busy;
                Dout[ST_FULL]             = fifoFull;
                Dout[ST_EMPTY]            = fifoEmpty;
                Dout[ST_OVF]              = ovf;
                Dout[ST_COUNT_LSB +: 4]   = cntField;
            end
            ADDR_CTRL: begin
                Dout[CTRL_TX_EN]  = txEn;
                Dout[CTRL_INT_EN] = intEn;
            end
            ADDR_DIV: Dout[15:0] = div;
            default:  Dout = '0;
        endcase
    end

    // bitDiv is latched at each bit start so a DIV write only affects the next bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bitCnt  <= '0;
            bitDiv  <= 16'(DIVISOR);
            bitIdx  <= '0;
            shifter <= '0;
        end else begin
            state <= stateNext;
            if (fifoPop) begin
                shifter <= fifoData;
                bitCnt  <= '0;
                bitDiv  <= div;
                bitIdx  <= '0;
            end else if (busy) begin
                if (bitEnd) begin
                    bitCnt <= '0;
                    bitDiv <= div;
                    if (state == S_DATA) bitIdx <= bitIdx + 3'd1;
                end else begin
                    bitCnt <= bitCnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stateNext = state;
        fifoPop   = 1'b0;
        tx        = 1'b1;
        bitEnd    = (bitCnt == bitDiv - 16'd1);
        case (state)
            S_IDLE: begin
                if (txEn && !fifoEmpty) begin
                    fifoPop   = 1'b1;
                    stateNext = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bitEnd) stateNext = S_DATA;
            end
            S_DATA: begin
                tx = shifter[bitIdx];
                if (bitEnd && bitIdx == 3'd7)
`ifdef UART_TX_PARITY_EN
                    stateNext = S_PARITY;
`else
                    stateNext = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx = ^shifter;
                if (bitEnd) stateNext = S_STOP;
            end
`endif
            S_STOP: begin
                if (bitEnd) stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

endmodule
